// File: rtl/id_hazard_if.sv
// rtl/id_hazard_if.sv - ID-stage decode/hazard handshake bundle between decoder and hazard controller
interface id_hazard_if #(
  parameter int REG_ADDR_LEN = 5,
  parameter int CNT_W        = 16
);
  logic                         id_valid;
  logic                         regaRd;
  logic [REG_ADDR_LEN-1:0]      regaAddr;
  logic                         regbRd;
  logic [REG_ADDR_LEN-1:0]      regbAddr;
  logic                         regcWr;
  logic [REG_ADDR_LEN-1:0]      regcAddr;
  logic                         stall;
  logic                         issue;
  logic                         bubble;
  logic [2**REG_ADDR_LEN-1:0]   pend_mask;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output id_valid, regaRd, regaAddr, regbRd, regbAddr, regcWr, regcAddr,
    input  stall, issue, bubble, pend_mask, stall_cnt
  );

  modport slave (
    input  id_valid, regaRd, regaAddr, regbRd, regbAddr, regcWr, regcAddr,
    output stall, issue, bubble, pend_mask, stall_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - RAW scoreboard that stalls ID and bubbles EX on pending register writes
module id_hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int WB_LAT       = 3,
  parameter int WR_BYPASS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        clr_cnt,
  id_hazard_if.slave  id
);
  // Slots at or beyond NCHK are either retired or being written this cycle (write-first regfile).
  localparam int NCHK = WB_LAT - WR_BYPASS;

  logic [WB_LAT-1:0]            v_q;
  logic [REG_ADDR_LEN-1:0]      addr_q [WB_LAT];
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;
  logic                         match_a;
  logic                         match_b;
  logic                         hazard;
  logic                         issue_d;
  logic                         slot_v_d;
  logic [2**REG_ADDR_LEN-1:0]   pend_d;

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < NCHK; i++) begin
      if (v_q[i] && (addr_q[i] == id.regaAddr)) match_a = 1'b1;
      if (v_q[i] && (addr_q[i] == id.regbAddr)) match_b = 1'b1;
    end
  end

  assign hazard   = id.id_valid &
                    ((id.regaRd & (id.regaAddr != '0) & match_a) |
                     (id.regbRd & (id.regbAddr != '0) & match_b));
  assign issue_d  = id.id_valid & ~hazard & ~hold;
  assign slot_v_d = issue_d & id.regcWr & (id.regcAddr != '0);

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (v_q[i]) pend_d[addr_q[i]] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hazard && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign id.stall     = ~rst & id.id_valid & (hazard | hold);
  assign id.issue     = ~rst & issue_d;
  assign id.bubble    = ~rst & ~hold & ~issue_d;
  assign id.pend_mask = rst ? '0 : pend_d;
  assign id.stall_cnt = cnt_q;

  // hold freezes both the tracker and the counter, including a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      for (int i = 1; i < WB_LAT; i++) begin
        v_q[i]    <= v_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      v_q[0]    <= slot_v_d;
      addr_q[0] <= id.regcAddr;
      cnt_q     <= cnt_d;
    end
  end
endmodule
